// File: rtl/stdp_neuron_array.sv
// Pair-based STDP neuron: N_IN plastic synapses feeding one leaky integrate-and-fire soma.
// Pre/post spike traces gate weight potentiation on fire and depression on pre spikes.
module stdp_neuron_array #(
  parameter int unsigned N_IN        = 4,
  parameter int unsigned W_BITS      = 8,
  parameter int unsigned V_BITS      = 10,
  parameter int unsigned THRESHOLD   = 230,
  parameter int unsigned TRACE_BITS  = 4,
  parameter int unsigned TRACE_MAX   = 15,
  parameter int unsigned A_POS_SHIFT = 1,
  parameter int unsigned A_NEG_SHIFT = 2,
  parameter int unsigned W_INIT      = 64,
  parameter int unsigned W_MIN       = 0,
  parameter int unsigned W_MAX       = 255
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [N_IN-1:0]                           pre_spike,
  input  logic                                      learn_en,
  input  logic                                      cfg_we,
  input  logic [((N_IN > 1) ? $clog2(N_IN) : 1)-1:0] cfg_addr,
  input  logic [W_BITS-1:0]                         cfg_wdata,
  output logic                                      post_spike,
  output logic [V_BITS-1:0]                         membrane,
  output logic [N_IN*W_BITS-1:0]                    weights
);

  localparam int unsigned MAX_VW = (V_BITS > W_BITS) ? V_BITS : W_BITS;
  localparam int unsigned SUM_W  = MAX_VW + $clog2(N_IN + 1) + 1;
  localparam int unsigned DW     = W_BITS + 2;

  localparam logic [V_BITS-1:0]     THR   = V_BITS'(THRESHOLD);
  localparam logic [SUM_W-1:0]      V_SAT = SUM_W'({V_BITS{1'b1}});
  localparam logic [TRACE_BITS-1:0] T_MAX = TRACE_BITS'(TRACE_MAX);
  localparam logic [W_BITS-1:0]     W_RST = W_BITS'(W_INIT);
  localparam logic signed [DW-1:0]  W_LO  = DW'(W_MIN);
  localparam logic signed [DW-1:0]  W_HI  = DW'(W_MAX);

  logic [N_IN-1:0][W_BITS-1:0]     w_q, w_next_c;
  logic [N_IN-1:0][TRACE_BITS-1:0] pre_trace_q, pre_trace_next_c;
  logic [TRACE_BITS-1:0]           post_trace_q, post_trace_next_c;
  logic [V_BITS-1:0]               mem_next_c;
  logic [SUM_W-1:0]                cur_c, mem_sum_c;
  logic                            fire_c;

  // Single clamp point shared by learning and the load port.
  function automatic logic [W_BITS-1:0] clamp_w(input logic signed [DW-1:0] x);
    if (x < W_LO)      return W_BITS'(W_LO);
    else if (x > W_HI) return W_BITS'(W_HI);
    else               return W_BITS'(x);
  endfunction

  function automatic logic [TRACE_BITS-1:0] trace_next(input logic spike,
                                                      input logic [TRACE_BITS-1:0] t);
    if (spike)         return T_MAX;
    else if (t != '0)  return t - TRACE_BITS'(1);
    else               return '0;
  endfunction

  assign fire_c  = (membrane >= THR);
  assign weights = w_q;

  // Soma: leak by 7/8, add current from the start-of-cycle weights, saturate.
  always_comb begin
    cur_c = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (pre_spike[i]) cur_c = cur_c + SUM_W'(w_q[i]);
    end
    mem_sum_c = SUM_W'(membrane >> 1) + SUM_W'(membrane >> 2) +
                SUM_W'(membrane >> 3) + cur_c;
    if (fire_c)                 mem_next_c = '0;
    else if (mem_sum_c > V_SAT) mem_next_c = {V_BITS{1'b1}};
    else                        mem_next_c = V_BITS'(mem_sum_c);
  end

  // Traces and weights; all STDP terms read the pre-update trace registers.
  always_comb begin
    logic signed [DW-1:0] d_pos;
    logic signed [DW-1:0] d_neg;
    w_next_c          = w_q;
    pre_trace_next_c  = pre_trace_q;
    post_trace_next_c = trace_next(fire_c, post_trace_q);
    d_pos             = '0;
    d_neg             = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      pre_trace_next_c[i] = trace_next(pre_spike[i], pre_trace_q[i]);
      d_pos = fire_c       ? DW'(pre_trace_q[i] >> A_POS_SHIFT) : '0;
      d_neg = pre_spike[i] ? DW'(post_trace_q >> A_NEG_SHIFT)   : '0;
      if (learn_en) w_next_c[i] = clamp_w($signed(DW'(w_q[i])) + d_pos - d_neg);
      if (cfg_we && (32'(cfg_addr) == i)) w_next_c[i] = clamp_w($signed(DW'(cfg_wdata)));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      membrane     <= '0;
      post_spike   <= 1'b0;
      post_trace_q <= '0;
      pre_trace_q  <= '0;
      w_q          <= {N_IN{W_RST}};
    end else begin
      membrane     <= mem_next_c;
      post_spike   <= (mem_next_c >= THR);
      post_trace_q <= post_trace_next_c;
      pre_trace_q  <= pre_trace_next_c;
      w_q          <= w_next_c;
    end
  end

endmodule

// File: tb/tb_stdp_neuron_array.sv
// Scoreboard bench for stdp_neuron_array: the driver queues hand-computed
// expected state per cycle, a negedge monitor pops and compares.
module tb_stdp_neuron_array;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  pre_spike;
  logic        learn_en;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [7:0]  cfg_wdata;
  logic        post_spike;
  logic [9:0]  membrane;
  logic [31:0] weights;

  typedef struct {
    string       name;
    logic [9:0]  m;
    logic        p;
    logic [31:0] w;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  stdp_neuron_array dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pre_spike  (pre_spike),
    .learn_en   (learn_en),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .post_spike (post_spike),
    .membrane   (membrane),
    .weights    (weights)
  );

  task automatic chk(input string nm, input string fld, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, expv);
    end
  endtask

  // Monitor: one expected record per cycle in which the driver queued one.
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk(e.name, "membrane", int'(membrane), int'(e.m));
        chk(e.name, "post_spike", int'(post_spike), int'(e.p));
        for (int i = 0; i < 4; i++)
          chk(e.name, $sformatf("w%0d", i), int'(weights[i*8 +: 8]), int'(e.w[i*8 +: 8]));
      end
    end
  end

  function automatic logic [31:0] wv(input int w3, input int w2, input int w1, input int w0);
    return {8'(w3), 8'(w2), 8'(w1), 8'(w0)};
  endfunction

  task automatic push(input string nm, input int m, input int p, input logic [31:0] w);
    exp_t x;
    x.name = nm;
    x.m    = 10'(m);
    x.p    = 1'(p);
    x.w    = w;
    q.push_back(x);
  endtask

  // Apply one cycle of inputs across a rising edge, return just after it.
  task automatic cyc(input logic [3:0] pre, input logic le, input logic we,
                     input logic [1:0] a, input logic [7:0] d);
    pre_spike = pre;
    learn_en  = le;
    cfg_we    = we;
    cfg_addr  = a;
    cfg_wdata = d;
    @(posedge clk);
    #1;
    pre_spike = '0;
    cfg_we    = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(4'h0, 1'b0, 1'b0, 2'd0, 8'd0);
    cyc(4'h0, 1'b0, 1'b0, 2'd0, 8'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; pre_spike = '0; learn_en = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;

    // T1 reset
    do_reset();
    push("t1_reset", 0, 0, wv(64, 64, 64, 64));

    // T2 integrate/fire with learning off
    cyc(4'hF, 1'b0, 1'b0, 2'd0, 8'd0); push("t2_c1", 256, 1, wv(64, 64, 64, 64));
    cyc(4'hF, 1'b0, 1'b0, 2'd0, 8'd0); push("t2_c2", 0,   0, wv(64, 64, 64, 64));
    cyc(4'hF, 1'b0, 1'b0, 2'd0, 8'd0); push("t2_c3", 256, 1, wv(64, 64, 64, 64));
    cyc(4'hF, 1'b0, 1'b0, 2'd0, 8'd0); push("t2_c4", 0,   0, wv(64, 64, 64, 64));

    // T3 LTP, T4 LTD
    do_reset();
    cyc(4'h0, 1'b1, 1'b1, 2'd0, 8'd240); push("t3_load", 0,   0, wv(64, 64, 64, 240));
    cyc(4'h1, 1'b1, 1'b0, 2'd0, 8'd0);   push("t3_int",  240, 1, wv(64, 64, 64, 240));
    cyc(4'h0, 1'b1, 1'b0, 2'd0, 8'd0);   push("t3_ltp",  0,   0, wv(64, 64, 64, 247));
    cyc(4'h2, 1'b1, 1'b0, 2'd0, 8'd0);   push("t4_ltd",  64,  0, wv(64, 64, 61, 247));

    // T5 floor clamp and load-over-learn priority
    do_reset();
    cyc(4'h0, 1'b1, 1'b1, 2'd2, 8'd1);   push("t5_ld2",  0,   0, wv(64, 1, 64, 64));
    cyc(4'h0, 1'b1, 1'b1, 2'd0, 8'd240); push("t5_ld0",  0,   0, wv(64, 1, 64, 240));
    cyc(4'h9, 1'b1, 1'b0, 2'd0, 8'd0);   push("t5_int",  304, 1, wv(64, 1, 64, 240));
    cyc(4'h0, 1'b1, 1'b1, 2'd3, 8'd9);   push("t5_prio", 0,   0, wv(9, 1, 64, 247));
    cyc(4'h4, 1'b1, 1'b0, 2'd0, 8'd0);   push("t5_floor", 1,  0, wv(9, 0, 64, 247));

    // T6 reset during a fire cycle with live traces
    do_reset();
    cyc(4'h0, 1'b1, 1'b1, 2'd0, 8'd240); push("t6_load", 0,   0, wv(64, 64, 64, 240));
    cyc(4'h1, 1'b1, 1'b0, 2'd0, 8'd0);   push("t6_int",  240, 1, wv(64, 64, 64, 240));
    rst_n = 1'b0;
    cyc(4'hF, 1'b1, 1'b1, 2'd1, 8'd200); push("t6_rst",  0,   0, wv(64, 64, 64, 64));
    rst_n = 1'b1;
    cyc(4'h0, 1'b1, 1'b1, 2'd0, 8'd240); push("t6_reld", 0,   0, wv(64, 64, 64, 240));
    cyc(4'h1, 1'b1, 1'b0, 2'd0, 8'd0);   push("t6_int2", 240, 1, wv(64, 64, 64, 240));
    cyc(4'h0, 1'b1, 1'b0, 2'd0, 8'd0);   push("t6_ltp",  0,   0, wv(64, 64, 64, 247));

    // T7 membrane saturation instead of wrap
    do_reset();
    cyc(4'h0, 1'b0, 1'b1, 2'd1, 8'd255); push("t7_ld1", 0, 0, wv(64, 64, 255, 64));
    cyc(4'h0, 1'b0, 1'b1, 2'd2, 8'd255); push("t7_ld2", 0, 0, wv(64, 255, 255, 64));
    cyc(4'h0, 1'b0, 1'b1, 2'd3, 8'd255); push("t7_ld3", 0, 0, wv(255, 255, 255, 64));
    cyc(4'h0, 1'b0, 1'b1, 2'd0, 8'd200); push("t7_ld0", 0, 0, wv(255, 255, 255, 200));
    cyc(4'h1, 1'b0, 1'b0, 2'd0, 8'd0);   push("t7_int", 200,  0, wv(255, 255, 255, 200));
    cyc(4'hF, 1'b0, 1'b0, 2'd0, 8'd0);   push("t7_sat", 1023, 1, wv(255, 255, 255, 200));

    for (int k = 0; k < 10 && q.size() != 0; k++) @(posedge clk);
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d records left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
